// File: rtl/rv32v_memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rv32v_memory_arbiter: shares one dcache port between scalar and vector LSU  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module rv32v_memory_arbiter #(
  parameter int NUM_CB_ENTRY = 16,
  parameter int ADDR_W       = 32,
  localparam int IW          = $clog2(NUM_CB_ENTRY)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              v_ena,
  input  logic [IW-1:0]     cb_tail_index,
  input  logic [IW-1:0]     vector_cb_index,
  input  logic [IW-1:0]     scalar_cb_index,
  input  logic              s_ren,
  input  logic              s_wen,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [ADDR_W-1:0] s_wdata,
  input  logic [3:0]        s_byte_en,
  output logic [ADDR_W-1:0] s_rdata,
  output logic              s_busy,
  input  logic              v_ren,
  input  logic              v_wen,
  input  logic [ADDR_W-1:0] v_addr,
  input  logic [ADDR_W-1:0] v_wdata,
  input  logic [3:0]        v_byte_en,
  output logic [ADDR_W-1:0] v_rdata,
  output logic              v_busy,
  output logic              m_ren,
  output logic              m_wen,
  output logic [ADDR_W-1:0] m_addr,
  output logic [ADDR_W-1:0] m_wdata,
  output logic [3:0]        m_byte_en,
  input  logic [ADDR_W-1:0] m_rdata,
  input  logic              m_busy,
  output logic              gnt_scalar,
  output logic              gnt_vector
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCALAR = 2'd1,
    ST_VECTOR = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            w_s_req;
  logic            w_v_req;
  logic [IW-1:0]   w_s_age;
  logic [IW-1:0]   w_v_age;

  assign w_s_req = s_ren | s_wen;
  assign w_v_req = v_ena & (v_ren | v_wen);
  // Distance from the oldest live entry; IW-bit wrap gives the modulo for free.
  assign w_s_age = scalar_cb_index - cb_tail_index;
  assign w_v_age = vector_cb_index - cb_tail_index;

  assign s_rdata = m_rdata;
  assign v_rdata = m_rdata;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    m_ren        = 1'b0;
    m_wen        = 1'b0;
    m_addr       = '0;
    m_wdata      = '0;
    m_byte_en    = 4'h0;
    s_busy       = 1'b1;
    v_busy       = 1'b1;
    gnt_scalar   = 1'b0;
    gnt_vector   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_s_req && w_v_req) begin
          // Ties go to the scalar side.
          w_state_next = (w_v_age < w_s_age) ? ST_VECTOR : ST_SCALAR;
        end else if (w_s_req) begin
          w_state_next = ST_SCALAR;
        end else if (w_v_req) begin
          w_state_next = ST_VECTOR;
        end
      end

      ST_SCALAR: begin
        gnt_scalar = 1'b1;
        m_addr     = s_addr;
        m_wdata    = s_wdata;
        m_byte_en  = s_byte_en;
        s_busy     = m_busy;
        if (w_s_req) begin
          m_ren = s_ren;
          m_wen = s_wen;
          if (!m_busy) begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end

      ST_VECTOR: begin
        gnt_vector = 1'b1;
        m_addr     = v_addr;
        m_wdata    = v_wdata;
        m_byte_en  = v_byte_en;
        v_busy     = m_busy;
        if (w_v_req) begin
          m_ren = v_ren;
          m_wen = v_wen;
          if (!m_busy) begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/rv32v_memory_arbiter.md
Name: rv32v_memory_arbiter

Overview:
- Consumer of the arbitor modport: one shared data-memory port serving the scalar LSU and the vector LSU.
- When both request, the one whose completion-buffer entry is older (closer to cb_tail_index) wins.
- The grant is locked until the memory transaction completes or the owner drops its request.
- Sits between the two LSUs and the dcache generic-bus port.

Parameters:
NUM_CB_ENTRY, 16, completion buffer depth (power of 2); index width IW = $clog2(NUM_CB_ENTRY)
ADDR_W, 32, address and data width

Ports:
CLK  input  1  clock
nRST  input  1  asynchronous active-low reset
v_ena  input  1  vector request is valid for arbitration
cb_tail_index  input  IW  oldest live CB entry
vector_cb_index  input  IW  CB entry of the vector request
scalar_cb_index  input  IW  CB entry of the scalar request
s_ren, s_wen  input  1 each  scalar read/write request
s_addr, s_wdata  input  ADDR_W each  scalar address/store data
s_byte_en  input  4  scalar byte enables
s_rdata  output  ADDR_W  load data to scalar
s_busy  output  1  low = scalar transaction complete this cycle
v_ren, v_wen, v_addr, v_wdata, v_byte_en  input  as scalar  vector request
v_rdata  output  ADDR_W  load data to vector
v_busy  output  1  low = vector transaction complete this cycle
m_ren, m_wen  output  1 each  memory request
m_addr, m_wdata  output  ADDR_W each  memory address/store data
m_byte_en  output  4  memory byte enables
m_rdata  input  ADDR_W  memory load data
m_busy  input  1  low = memory transaction complete
gnt_scalar, gnt_vector  output  1 each  current owner (one-hot or zero)

Behaviour:
- Requests: s_req = s_ren|s_wen; v_req = v_ena & (v_ren|v_wen). A vector request with v_ena=0 is invisible.
- Age: s_age = (scalar_cb_index - cb_tail_index) mod NUM_CB_ENTRY; v_age likewise, computed in IW bits with natural wrap. Smaller age = older.
- FSM states: IDLE, SCALAR, VECTOR. Reset state is IDLE.
- IDLE:
  - only s_req -> SCALAR; only v_req -> VECTOR.
  - both: s_age < v_age -> SCALAR; v_age < s_age -> VECTOR; equal -> SCALAR.
  - neither: stay IDLE.
  - No memory request is issued while in IDLE.
- SCALAR/VECTOR:
  - m_ren/m_wen/m_addr/m_wdata/m_byte_en are combinationally the owner's inputs.
  - Owner busy = m_busy. Non-owner busy = 1.
  - On a cycle with owner request high and m_busy=0: completion; next state IDLE.
  - Owner request low (abort): m_ren=m_wen=0 that cycle; next state IDLE.
  - The non-owner is never granted mid-transaction, even if older.
  - Changes to CB indices while granted are ignored.
- Latency: a request first seen in IDLE at cycle N drives the memory from cycle N+1. After completion there is one IDLE cycle for re-arbitration, so back-to-back transactions are spaced by at least 1 cycle.
- Outputs in IDLE and during reset: m_ren=m_wen=0, m_addr=m_wdata=0, m_byte_en=0, s_busy=v_busy=1, gnt_*=0.
- s_rdata = v_rdata = m_rdata always. Data is only meaningful to the owner when its busy is low.
- gnt_scalar = (state==SCALAR); gnt_vector = (state==VECTOR).
- s_ren and s_wen asserted together: forwarded as-is; the memory side defines the result. Same for the vector side.
- Reset mid-transaction: asynchronous return to IDLE, outputs to reset values immediately. No completion is reported to either side.
- Requesters hold their request until they see busy low; this arbiter requires that.

Test Plan:
- Scalar-only: s_ren=1, s_addr=0x100, m_busy=0 on 3rd cycle of grant → m_ren=1, m_addr=0x100 from cycle N+1; s_busy=0 for 1 cycle; v_busy=1 throughout; IDLE after.
- Age with wrap (N=16): tail=14, scalar_idx=1 (age 3), vector_idx=15 (age 1), both request, v_ena=1 → VECTOR granted, gnt_vector=1. Then scalar granted after vector completes and one IDLE cycle.
- Scalar older: tail=2, scalar_idx=3, vector_idx=9, both request → SCALAR. With v_ena=0 and s idle, vector is never granted.
- Lock: grant SCALAR, then swap indices so vector is older mid-transaction → still SCALAR until m_busy=0.
- Abort: VECTOR granted, v_wen dropped before m_busy=0 → m_wen=0 same cycle, IDLE next, v_busy stays 1.
- Reset mid-transaction: nRST low while SCALAR with m_busy=1 → immediately m_ren=0, gnt_scalar=0, s_busy=1. After release, a pending request is re-arbitrated from IDLE.
